// File: rtl/sort_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// sort_stream_ctrl_pkg : shared frame geometry and FSM encoding
// Revision: 1.0
// ============================================================================
package sort_stream_ctrl_pkg;

  localparam int FRAME_LEN = 8;
  localparam int DATA_W    = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    LOAD    = 3'd1,
    SORT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  typedef logic [FRAME_LEN-1:0][DATA_W-1:0] frame_t;

endpackage
`default_nettype wire

// File: rtl/sort_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// sort_stream_ctrl_if : upstream, sorter and downstream signals of the block
// Revision: 1.0
// ============================================================================
interface sort_stream_ctrl_if;
  import sort_stream_ctrl_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic [DATA_W-1:0] sort_in1, sort_in2, sort_in3, sort_in4;
  logic [DATA_W-1:0] sort_in5, sort_in6, sort_in7, sort_in8;
  logic              sort_ready;
  logic              sort_rst_n;
  logic [DATA_W-1:0] sort_out1, sort_out2, sort_out3, sort_out4;
  logic [DATA_W-1:0] sort_out5, sort_out6, sort_out7, sort_out8;
  logic              sort_done;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              err_timeout;

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output sort_in1, sort_in2, sort_in3, sort_in4,
    output sort_in5, sort_in6, sort_in7, sort_in8,
    output sort_ready, sort_rst_n,
    input  sort_out1, sort_out2, sort_out3, sort_out4,
    input  sort_out5, sort_out6, sort_out7, sort_out8,
    input  sort_done,
    output out_valid, out_data, out_last,
    input  out_ready,
    output err_timeout
  );

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  sort_in1, sort_in2, sort_in3, sort_in4,
    input  sort_in5, sort_in6, sort_in7, sort_in8,
    input  sort_ready, sort_rst_n,
    output sort_out1, sort_out2, sort_out3, sort_out4,
    output sort_out5, sort_out6, sort_out7, sort_out8,
    output sort_done,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sort_result_buf.sv
`default_nettype none
// ============================================================================
// sort_result_buf : 8-entry result buffer with in-order read pointer
// Revision: 1.0
// ============================================================================
module sort_result_buf
  import sort_stream_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  frame_t            din,
  input  logic              advance,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  frame_t           result;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      rd_ptr <= '0;
    end else if (capture) begin
      result <= din;
      rd_ptr <= '0;
    end else if (advance) begin
      rd_ptr <= rd_ptr + IDX_W'(1);
    end
  end

  assign out_data = result[rd_ptr];
  assign out_last = (rd_ptr == IDX_W'(FRAME_LEN - 1));

endmodule
`default_nettype wire

// File: rtl/sort_stream_ctrl.sv
`default_nettype none
// ============================================================================
// sort_stream_ctrl : loads 8 bytes, runs an external sorter, streams results
// Revision: 1.0
// ============================================================================
module sort_stream_ctrl
  import sort_stream_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  sort_stream_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  sort_cnt;
  frame_t            slots;
  frame_t            sorted;
  logic              sort_rst_q;
  logic              err_q;
  logic              in_fire;
  logic              out_fire;
  logic              timed_out;
  logic              buf_last;
  logic [DATA_W-1:0] buf_data;

  assign in_fire   = bus.in_valid && (state == LOAD);
  assign out_fire  = bus.out_ready && (state == DRAIN);
  // sort_done on the final allowed cycle still wins over the timeout
  assign timed_out = (state == SORT) && !bus.sort_done
                     && (sort_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   state_nxt = LOAD;
      LOAD:    if (in_fire && (idx == IDX_W'(FRAME_LEN - 1))) state_nxt = SORT;
      SORT:    if (bus.sort_done) state_nxt = CAPTURE;
               else if (timed_out) state_nxt = CLEAR;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   if (out_fire && buf_last) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      slots      <= '0;
      sort_cnt   <= '0;
      sort_rst_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // sorter clear is low exactly while the FSM sits in CLEAR
      sort_rst_q <= (state_nxt != CLEAR);
      if (state == CLEAR) begin
        idx <= '0;
      end else if (in_fire) begin
        slots[idx] <= bus.in_data;
        idx        <= idx + IDX_W'(1);
      end
      if (state == SORT) sort_cnt <= sort_cnt + CNT_W'(1);
      else               sort_cnt <= '0;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign sorted = {bus.sort_out8, bus.sort_out7, bus.sort_out6, bus.sort_out5,
                   bus.sort_out4, bus.sort_out3, bus.sort_out2, bus.sort_out1};

  sort_result_buf u_result_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (state == CAPTURE),
    .din      (sorted),
    .advance  (out_fire),
    .out_data (buf_data),
    .out_last (buf_last)
  );

  assign bus.in_ready    = (state == LOAD);
  assign bus.sort_ready  = (state == SORT);
  assign bus.sort_rst_n  = sort_rst_q;
  assign bus.out_valid   = (state == DRAIN);
  assign bus.out_data    = (state == DRAIN) ? buf_data : '0;
  assign bus.out_last    = (state == DRAIN) && buf_last;
  assign bus.err_timeout = err_q;

  assign bus.sort_in1 = slots[0];
  assign bus.sort_in2 = slots[1];
  assign bus.sort_in3 = slots[2];
  assign bus.sort_in4 = slots[3];
  assign bus.sort_in5 = slots[4];
  assign bus.sort_in6 = slots[5];
  assign bus.sort_in7 = slots[6];
  assign bus.sort_in8 = slots[7];

endmodule
`default_nettype wire

// File: tb/tb_sort_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sort_stream_ctrl : random frames against a sorter model and scoreboard
// Revision: 1.0
// ============================================================================
module tb_sort_stream_ctrl;

  localparam int TIMEOUT = 15;
  typedef logic [7:0] frame_u_t [8];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   ready_mode = 0;
  int   rcyc = 0;
  int   sorter_lat = 8;
  bit   sorter_never = 1'b0;
  int   cyc = 0;
  int   out_beats = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  sort_stream_ctrl_if bus();

  sort_stream_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint expv);
    chk_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  function automatic frame_u_t sort8(input frame_u_t a);
    frame_u_t   r;
    logic [7:0] t;
    r = a;
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    return r;
  endfunction

  // ---------------- sorter model: sorts after sorter_lat enabled cycles
  frame_u_t   s_in, s_out;
  logic       s_done;
  int         s_cnt;

  assign s_in[0] = bus.sort_in1;  assign s_in[1] = bus.sort_in2;
  assign s_in[2] = bus.sort_in3;  assign s_in[3] = bus.sort_in4;
  assign s_in[4] = bus.sort_in5;  assign s_in[5] = bus.sort_in6;
  assign s_in[6] = bus.sort_in7;  assign s_in[7] = bus.sort_in8;
  assign bus.sort_out1 = s_out[0]; assign bus.sort_out2 = s_out[1];
  assign bus.sort_out3 = s_out[2]; assign bus.sort_out4 = s_out[3];
  assign bus.sort_out5 = s_out[4]; assign bus.sort_out6 = s_out[5];
  assign bus.sort_out7 = s_out[6]; assign bus.sort_out8 = s_out[7];
  assign bus.sort_done = s_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_done <= 1'b0; s_cnt <= 0; s_out <= '{default: 8'h00};
    end else if (!bus.sort_rst_n) begin
      s_done <= 1'b0; s_cnt <= 0;
    end else if (bus.sort_ready && !s_done && !sorter_never) begin
      if (s_cnt + 1 >= sorter_lat) begin
        s_done <= 1'b1;
        s_out  <= sort8(s_in);
      end
      s_cnt <= s_cnt + 1;
    end
  end

  // ---------------- downstream ready patterns
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (rcyc % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rcyc++;
    end
  end

  // ---------------- per-cycle compare process
  logic       pv = 0, pr = 0, pl = 0, pdone = 0;
  logic [7:0] pd = 0;
  logic [8:0] e;
  int         vrun = 0, done_cyc = -100, low_len = 0, in_beats = 0;
  bit         rst_seen = 1, clear_seen = 1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv = 0; vrun = 0; done_cyc = -100; pdone = 0; low_len = 0;
      rst_seen = 1; clear_seen = 1; in_beats = 0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, pd);
        check("stall_last", bus.out_last, pl);
      end
      if (!bus.out_valid) check("last_without_valid", bus.out_last, 0);
      check("phase_exclusive",
            int'(bus.in_ready) + int'(bus.sort_ready) + int'(bus.out_valid) > 1, 0);
      if (bus.out_valid && !pv) check("first_out_latency", cyc - done_cyc, 2);
      if (bus.sort_done && !pdone && bus.sort_ready) done_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check("beat_has_expectation", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e[7:0]);
          check("out_last", bus.out_last, e[8]);
        end
        out_beats++;
      end
      if (bus.out_valid) vrun++;
      else begin
        if (pv && ready_mode == 0) check("burst_len", vrun, 8);
        vrun = 0;
      end
      if (!bus.sort_rst_n) begin
        low_len++; clear_seen = 1;
      end else begin
        if (low_len > 0 && !rst_seen) check("clear_pulse_len", low_len, 1);
        if (low_len > 0) rst_seen = 0;
        low_len = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (in_beats % 8 == 0) begin
          check("clear_before_frame", clear_seen, 1);
          clear_seen = 0;
        end
        in_beats++;
      end
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
      pl = bus.out_last;  pdone = bus.sort_done;
    end
  end

  // ---------------- stimulus
  task automatic put_byte(input logic [7:0] b);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk); #1;
    end
    check("in_accept", ok, 1);
  endtask

  task automatic send_frame(input frame_u_t f, input int gap, input bit expect_out);
    frame_u_t s;
    for (int i = 0; i < 8; i++) begin
      put_byte(f[i]);
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    if (expect_out) begin
      s = sort8(f);
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), s[i]});
    end
  endtask

  task automatic wait_drained();
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
    check("drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic frame_u_t rand_frame();
    frame_u_t f;
    for (int i = 0; i < 8; i++) f[i] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    frame_u_t fa, fb, r;
    int       base;
    fa = '{8'd8, 8'd3, 8'd7, 8'd1, 8'd6, 8'd2, 8'd5, 8'd4};
    fb = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'hC0};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // model pins against hand-sorted literals
    r = sort8(fa);
    for (int i = 0; i < 8; i++) check("model_pin_a", r[i], i + 1);
    r = sort8(fb);
    check("model_pin_b0", r[0], 8'h00); check("model_pin_b3", r[3], 8'h7F);
    check("model_pin_b6", r[6], 8'hFE); check("model_pin_b7", r[7], 8'hFF);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);     check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);     check("rst_out_data", bus.out_data, 0);
    check("rst_sort_ready", bus.sort_ready, 0); check("rst_sort_rst_n", bus.sort_rst_n, 0);
    check("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;

    // ascending result, full-rate sink
    ready_mode = 0; sorter_lat = 8;
    send_frame(fa, 0, 1);
    wait_drained();

    // 1,0,0 stall pattern on the sink
    ready_mode = 1;
    send_frame(fa, 0, 1);
    wait_drained();

    // gapped input, then junk held on in_valid while sorting
    ready_mode = 0;
    send_frame(fa, 3, 1);
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    @(negedge clk);
    check("in_ready_after_8", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drained();

    // sort_done on the last allowed cycle still succeeds
    ready_mode = 2; sorter_lat = TIMEOUT;
    send_frame(rand_frame(), 0, 1);
    wait_drained();
    check("no_err_at_boundary", bus.err_timeout, 0);

    // sorter never answers
    sorter_never = 1'b1;
    send_frame(rand_frame(), 0, 0);
    for (int k = 0; k <= TIMEOUT + 1; k++) begin
      @(negedge clk);
      check("timeout_sort_ready", bus.sort_ready, (k <= TIMEOUT));
      check("timeout_err", bus.err_timeout, (k > TIMEOUT));
    end
    @(posedge clk); #1;
    sorter_never = 1'b0;

    // next frame recovers; error stays sticky
    ready_mode = 0; sorter_lat = $urandom_range(1, 10);
    send_frame(rand_frame(), 1, 1);
    wait_drained();
    check("err_sticky", bus.err_timeout, 1);

    // reset in the middle of DRAIN
    sorter_lat = 5;
    send_frame(rand_frame(), 0, 1);
    base = out_beats;
    for (int n = 0; n < 200 && out_beats < base + 3; n++) @(negedge clk);
    check("three_beats_before_reset", out_beats - base, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0); check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_last", bus.out_last, 0);   check("midrst_err", bus.err_timeout, 0);
    check("midrst_sort_rst_n", bus.sort_rst_n, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(fb, 0, 1);
    wait_drained();

    // back-to-back random frames
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      sorter_lat = $urandom_range(1, TIMEOUT);
      send_frame(rand_frame(), $urandom_range(0, 2), 1);
    end
    wait_drained();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_stream_ctrl.md
SORT_STREAM_CTRL -- requirements
Module: sort_stream_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles in SORT before the timeout error.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_data  input  8  upstream byte.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have ports sort_in1..sort_in8  output  8 each  operands to the sorter data_in1..8.
REQ-008 SHALL have port sort_ready  output  1  sorter enable (sorter ready input).
REQ-009 SHALL have port sort_rst_n  output  1  registered active-low clear of the sorter, driven from a flop.
REQ-010 SHALL have ports sort_out1..sort_out8  input  8 each  sorter results data_out1..8.
REQ-011 SHALL have port sort_done  input  1  sorter done.
REQ-012 SHALL have port out_valid  output  1  result byte valid.
REQ-013 SHALL have port out_data  output  8  result byte.
REQ-014 SHALL have port out_last  output  1  marks the 8th result byte of a frame.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the result byte.
REQ-016 SHALL have port err_timeout  output  1  sticky flag: sort_done missing.

Function
REQ-017 SHALL implement FSM states CLEAR, LOAD, SORT, CAPTURE, DRAIN.
REQ-018 CLEAR SHALL drive sort_rst_n=0 for exactly 1 cycle, then go to LOAD.
REQ-019 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready beat SHALL store in_data into slot idx (0..7) and increment idx.
REQ-020 The beat with idx==7 SHALL move the FSM to SORT next cycle; in_ready SHALL be 0 in every state other than LOAD.
REQ-021 sort_inN SHALL hold slot N-1 unchanged from the end of LOAD until the next LOAD writes it.
REQ-022 In SORT, sort_ready SHALL be 1; otherwise sort_ready SHALL be 0.
REQ-023 In SORT, a cycle counter SHALL count from 0; sort_done=1 moves the FSM to CAPTURE.
REQ-024 If the counter reaches TIMEOUT without sort_done, the block SHALL set err_timeout=1 and go to CLEAR, discarding the frame with no output.
REQ-025 CAPTURE SHALL register sort_out1..8 into an 8x8 result buffer in one cycle, then go to DRAIN.
REQ-026 DRAIN SHALL present result[0] first, then result[1]..result[7] in order, with out_valid=1.
REQ-027 out_data SHALL advance only on out_valid&&out_ready; out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 out_last SHALL be 1 only with result[7]; acceptance of that beat SHALL go to CLEAR.
REQ-029 Back-to-back frame latency SHALL be: last input beat -> first out_valid = sort_done arrival + 2 cycles; sorter round trip = 10 cycles with a compliant sorter.
REQ-030 in_valid SHALL be ignored outside LOAD; no input beat SHALL be lost or duplicated within LOAD.
REQ-031 err_timeout SHALL clear only on rst_n.

Reset
REQ-032 rst_n low SHALL asynchronously force:
- state = CLEAR, idx = 0
- slots and result buffer = 0
- in_ready, out_valid, out_last, sort_ready, err_timeout = 0
- out_data = 0
- sort_rst_n = 0
REQ-033 Reset asserted mid-LOAD, SORT or DRAIN SHALL abandon the frame; after release the first out beat SHALL belong to a new 8-byte frame.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, FRAME_LEN=8 and DATA_W=8.
REQ-035 The 8x8 result buffer with its read pointer SHALL be one sub-module, sort_result_buf; the FSM and load slots remain top-level.

Verification
REQ-036 Load 8,3,7,1,6,2,5,4 with a real sorter and out_ready=1 -> out 1..8 ascending, one per cycle, out_last only on 8.
REQ-037 Same frame with out_ready toggled 1,0,0,1,... -> no dropped or duplicated beats; out_data stable during stalls.
REQ-038 in_valid gaps of 3 cycles between input beats -> identical result; in_ready=0 once 8 beats are taken.
REQ-039 Sorter model never asserts sort_done -> err_timeout=1 at cycle TIMEOUT of SORT, no out_valid, next frame processed correctly.
REQ-040 rst_n pulsed during DRAIN after 3 beats -> outputs zero immediately; a new frame 0xFF,0x00,... sorts to 0x00..0xFF order.
REQ-041 Two back-to-back frames -> sort_rst_n pulses low for 1 cycle before each frame; second result uncorrupted by the first.
